// File: rtl/sram_pkg.sv
// Shared types and helpers for the synchronous SRAM controller.
// Define SRAM_PARITY_EN to add one even-parity bit per stored word.
package sram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

`ifdef SRAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  function automatic int clog2_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic par_f(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_array.sv
// DEPTH x W storage: one write port, one registered read port.
// The storage itself is never reset; only the read register is.
module sram_array #(
  parameter int W     = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_sync_ctrl.sv
// Synchronous single-port SRAM controller: clear-on-reset, valid/ready
// requests, RD_LAT 1 or 2. Optional SRAM_PARITY_EN adds parity checking.
module sram_sync_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done,
  output logic              rsp_perr
);

  localparam int CW = clog2_f(DEPTH);
  localparam int SW = DATA_W + PAR_W;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam bit FULL =
    (64'(DEPTH) == (64'd1 << ADDR_W));

  state_e          state_q, state_d;
  logic [CW-1:0]   clr_q, clr_d;
  logic            init_q, init_d;
  logic            v1_q, v1_d;
  logic            err1_q, err1_d;

  logic            oor, acc;
  logic            arr_we, arr_re;
  logic [CW-1:0]   arr_waddr;
  logic [SW-1:0]   arr_wdata, wword, arr_rdata;
  logic [DATA_W-1:0] d1;
  logic            perr1;

  generate
    if (FULL) begin : g_full
      assign oor = 1'b0;
    end else begin : g_part
      assign oor = req_addr >= ADDR_W'(DEPTH);
    end
  endgenerate

  assign req_ready = cs & init_q;
  assign acc       = req_valid & req_ready;

`ifdef SRAM_PARITY_EN
  assign wword = {par_f(64'(req_wdata)), req_wdata};
`else
  assign wword = req_wdata;
`endif

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    init_d    = init_q;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_waddr = clr_q;
    arr_wdata = '0;
    unique case (state_q)
      ST_INIT: begin
        arr_we = 1'b1;
        if (clr_q == LAST) begin
          state_d = ST_IDLE;
          init_d  = 1'b1;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (acc && !oor) begin
          arr_we    = req_we;
          arr_re    = !req_we;
          arr_waddr = req_addr[CW-1:0];
          arr_wdata = wword;
        end
      end
    endcase
    v1_d   = acc & ~req_we;
    err1_d = v1_d ? oor : err1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
      init_q  <= 1'b0;
      v1_q    <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      init_q  <= init_d;
      v1_q    <= v1_d;
      err1_q  <= err1_d;
    end
  end

  sram_array #(
    .W     (SW),
    .DEPTH (DEPTH),
    .AW    (CW)
  ) u_arr (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (req_addr[CW-1:0]),
    .rdata (arr_rdata)
  );

  // Out-of-range reads never touch the array, so zero the data here.
  assign d1 = err1_q ? '0 : arr_rdata[DATA_W-1:0];

`ifdef SRAM_PARITY_EN
  assign perr1 = ~err1_q &
    (par_f(64'(d1)) ^ arr_rdata[DATA_W]);
`else
  assign perr1 = 1'b0;
`endif

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2_q;
      logic [DATA_W-1:0] d2_q;
      logic              e2_q, p2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q <= 1'b0;
          d2_q <= '0;
          e2_q <= 1'b0;
          p2_q <= 1'b0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) begin
            d2_q <= d1;
            e2_q <= err1_q;
            p2_q <= perr1;
          end
        end
      end

      assign rsp_valid = v2_q;
      assign rsp_rdata = d2_q;
      assign rsp_err   = e2_q;
      assign rsp_perr  = p2_q;
    end else begin : g_lat1
      assign rsp_valid = v1_q;
      assign rsp_rdata = d1;
      assign rsp_err   = err1_q;
      assign rsp_perr  = perr1;
    end
  endgenerate

  assign init_done = init_q;

endmodule
